// File: rtl/soc_system_key_pio_irq_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// The master side drives the address and strobes; the slave side returns registered read data.
interface soc_system_key_pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_key_pio_irq.sv
// Input PIO for push-buttons and switches.
// Pin path: 2-flop synchroniser, then per-bit debounce, then edge detection.
// Captured edges are kept in a write-1-to-clear register. They are gated by a
// per-bit mask to form a level interrupt for the HPS.
module soc_system_key_pio_irq #(
  parameter int unsigned       WIDTH           = 32'd4,
  parameter int unsigned       DEBOUNCE_CYCLES = 32'd50000,
  parameter int unsigned       EDGE_TYPE       = 32'd1,
  parameter logic [WIDTH-1:0]  INIT            = 4'hF
) (
  input  logic                     clk,
  input  logic                     reset,
  soc_system_key_pio_irq_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] deb_d_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [31:0]      readdata_r;

  logic             wr_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      rd_mux_s;

  assign wr_s         = bus.chipselect & ~bus.write_n;
  assign bus.readdata = readdata_r;

  // Two-stage synchroniser for the asynchronous pins; idles at INIT out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= INIT;
      s_r  <= INIT;
    end else begin
      s1_r <= in_port;
      s_r  <= s1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 32'd0) begin : g_bypass
      assign deb_s = s_r;
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 32'd1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

      logic [CW-1:0]    cnt_r [WIDTH];
      logic [WIDTH-1:0] deb_r;

      // Per-bit stability counter: the bit flips only after DEBOUNCE_CYCLES differing cycles in a row.
      always_ff @(posedge clk) begin
        if (reset) begin
          deb_r <= INIT;
          for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_r[i] <= {CW{1'b0}};
          end
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (s_r[i] == deb_r[i]) begin
              cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] == LAST) begin
              deb_r[i] <= s_r[i];
              cnt_r[i] <= {CW{1'b0}};
            end else begin
              cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
      end

      assign deb_s = deb_r;
    end
  endgenerate

  // Edge detection on the debounced value and selection of the edge flavour to capture.
  always_comb begin
    rise_s = deb_s & ~deb_d_r;
    fall_s = ~deb_s & deb_d_r;
    case (EDGE_TYPE)
      32'd0:   edge_s = rise_s;
      32'd1:   edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase
  end

  // Write-1-to-clear mask for edgecapture; only a write to word 3 clears anything.
  always_comb begin
    if (wr_s && (bus.address == 2'd3)) begin
      clr_s = bus.writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Read multiplexer; unimplemented upper bits and the reserved word read as zero.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.address)
      2'd0:    rd_mux_s = 32'(deb_s);
      2'd1:    rd_mux_s = 32'h0000_0000;
      2'd2:    rd_mux_s = 32'(irqmask_r);
      2'd3:    rd_mux_s = 32'(edgecap_r);
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Control registers, edge history and registered read data.
  // A new edge is ORed in after the clear, so it wins over a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d_r    <= INIT;
      irqmask_r  <= {WIDTH{1'b0}};
      edgecap_r  <= {WIDTH{1'b0}};
      readdata_r <= 32'h0000_0000;
    end else begin
      deb_d_r <= deb_s;
      if (wr_s && (bus.address == 2'd2)) begin
        irqmask_r <= bus.writedata[WIDTH-1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
      edgecap_r  <= (edgecap_r & ~clr_s) | edge_s;
      readdata_r <= rd_mux_s;
    end
  end

  // The interrupt level comes straight from the registers, so a mask change takes effect immediately.
  assign irq = |(edgecap_r & irqmask_r);

endmodule

// File: tb/tb_soc_system_key_pio_irq.sv
// Directed bench for soc_system_key_pio_irq with WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture and INIT=4'hF.
// Inputs change on the falling clock edge, and outputs are sampled there as well.
module tb_soc_system_key_pio_irq;

  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;
  int         total;
  int         bad;
  logic [31:0] rd;

  soc_system_key_pio_irq_if bus();

  soc_system_key_pio_irq #(
    .WIDTH           (32'd4),
    .DEBOUNCE_CYCLES (32'd4),
    .EDGE_TYPE       (32'd1),
    .INIT            (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    cycle(1);
    data           = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    cycle(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    in_port = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    @(negedge clk);

    // 1: reset state
    cycle(3);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    bus_read(2'd0, rd);
    check("reset_data", rd, 32'h0000_000F);
    bus_read(2'd2, rd);
    check("reset_mask", rd, 32'h0);

    // 2: debounce latency, measured through data reads with address 0 held
    bus.address    = 2'd0;
    bus.chipselect = 1'b1;
    in_port = 4'hE;
    cycle(6);
    check("deb_not_yet", bus.readdata, 32'h0000_000F);
    cycle(1);
    check("deb_followed", bus.readdata, 32'h0000_000E);
    bus.chipselect = 1'b0;
    // A 3-cycle glitch on bit1 is shorter than the debounce window.
    in_port = 4'hC;
    cycle(3);
    in_port = 4'hE;
    cycle(10);
    bus_read(2'd0, rd);
    check("glitch_data", rd, 32'h0000_000E);
    bus_read(2'd3, rd);
    check("glitch_edgecap", rd, 32'h0000_0001);
    check("glitch_irq_masked", {31'd0, irq}, 32'h0);
    bus_write(2'd3, 32'h0000_000F);
    bus_read(2'd3, rd);
    check("w1c_all", rd, 32'h0);
    // A rising edge must not be captured.
    in_port = 4'hF;
    cycle(10);
    bus_read(2'd0, rd);
    check("release_data", rd, 32'h0000_000F);
    bus_read(2'd3, rd);
    check("rise_ignored", rd, 32'h0);

    // 3: edge capture and irq timing
    bus_write(2'd2, 32'h0000_0001);
    bus_read(2'd2, rd);
    check("mask_rb", rd, 32'h0000_0001);
    in_port = 4'hE;
    cycle(6);
    check("irq_before_cap", {31'd0, irq}, 32'h0);
    cycle(1);
    check("irq_at_cap", {31'd0, irq}, 32'h1);
    bus_read(2'd3, rd);
    check("edgecap_bit0", rd, 32'h0000_0001);
    bus_write(2'd3, 32'h0000_0001);
    check("irq_after_w1c", {31'd0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("edgecap_cleared", rd, 32'h0);
    in_port = 4'hF;
    cycle(10);

    // 4: masking a pending bit
    bus_write(2'd2, 32'h0000_0000);
    in_port = 4'hB;
    cycle(10);
    check("masked_irq", {31'd0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("pending_bit2", rd, 32'h0000_0004);
    bus_write(2'd2, 32'h0000_0004);
    check("unmask_irq", {31'd0, irq}, 32'h1);
    bus_write(2'd2, 32'h0000_0000);
    check("remask_irq", {31'd0, irq}, 32'h0);
    bus_write(2'd3, 32'h0000_0004);
    in_port = 4'hF;
    cycle(10);
    bus_read(2'd3, rd);
    check("bit2_cleared", rd, 32'h0);

    // 5: a W1C that lands on the same edge as a new capture loses to the capture
    bus_write(2'd2, 32'h0000_0001);
    in_port = 4'hE;
    cycle(10);
    in_port = 4'hF;
    cycle(10);
    check("race_pending_irq", {31'd0, irq}, 32'h1);
    in_port = 4'hE;
    cycle(6);
    bus_write(2'd3, 32'h0000_0001);
    check("race_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd3, rd);
    check("race_edgecap", rd, 32'h0000_0001);
    bus_write(2'd3, 32'h0000_0001);
    check("race_cleared_irq", {31'd0, irq}, 32'h0);
    in_port = 4'hF;
    cycle(10);

    // 6: reset in the middle of a debounce window
    in_port = 4'hB;
    cycle(2);
    reset   = 1'b1;
    in_port = 4'hF;
    cycle(1);
    reset = 1'b0;
    check("midreset_irq", {31'd0, irq}, 32'h0);
    check("midreset_readdata", bus.readdata, 32'h0);
    cycle(10);
    bus_read(2'd0, rd);
    check("midreset_data", rd, 32'h0000_000F);
    bus_read(2'd3, rd);
    check("midreset_edgecap", rd, 32'h0);
    bus_read(2'd2, rd);
    check("midreset_mask", rd, 32'h0);

    // Reserved word reads zero and ignores writes.
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd);
    check("reserved", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
